utimer_ctrl8: RTL and testbench
===============================

Name: utimer_ctrl8

Overview:
Programmable interval-timer controller for the 8-bit universal counter datapath.
- Accepts start/stop/abort commands over a valid/ready handshake and latches the configuration.
- Sequences the counter: preload, prescaled up/down stepping, terminal detection, one-shot or periodic reload.
- Raises an expire pulse and a sticky interrupt toward the system interrupt logic.

Parameters:
WIDTH, 8, counter width; terminal values are 0 and 2^WIDTH-1
PRESC_W, 4, prescaler field width; step period = cfg_presc+1 clocks

Ports:
clk  input  1  rising-edge clock
_areset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command can be accepted this cycle
cmd_op  input  2  00 NOP, 01 START, 10 STOP, 11 ABORT
cfg_preld  input  WIDTH  preload value, sampled on an accepted START from IDLE
cfg_updown  input  1  1 = count up, 0 = count down (sampled with cfg_preld)
cfg_periodic  input  1  1 = auto-reload at terminal, 0 = one-shot (sampled with cfg_preld)
cfg_presc  input  PRESC_W  prescale divisor minus one (sampled with cfg_preld)
irq_ack  input  1  clears irq
dcount  output  WIDTH  current count
expire  output  1  one-cycle pulse on terminal step
irq  output  1  sticky, set by expire
busy  output  1  state != IDLE

Behaviour:
- Reset (async, any time, including mid-run): state=IDLE, dcount=0, prescaler=0, shadow config=0, expire=0, irq=0, busy=0.
- Handshake: a command is accepted on an edge where cmd_valid & cmd_ready. cmd_ready=1 in IDLE, RUN and PAUSE; 0 in ARM. NOP is accepted with no effect.
- States: IDLE, ARM, RUN, PAUSE.
- IDLE
  - START: latch cfg_* into shadow registers; next state ARM.
  - STOP, ABORT: no effect.
- ARM (exactly one cycle): dcount<=shadow preld, prescaler<=0, next state RUN.
- RUN
  - Each edge: if prescaler==shadow presc, a step occurs and prescaler<=0; otherwise prescaler+=1.
  - Step at a non-terminal count: dcount +1 (up) or -1 (down).
  - Step at terminal (dcount==255 with up, ==0 with down):
    - expire=1 for the next cycle; irq<=1.
    - Periodic: dcount<=shadow preld, stay RUN.
    - One-shot: dcount holds the terminal value, next state IDLE.
  - Counting never wraps through the terminal value.
- START in RUN: accepted, no effect.
- STOP in RUN: next state PAUSE; dcount and prescaler hold; any step due on that edge is discarded.
- PAUSE
  - START: resume RUN with prescaler and dcount unchanged; config is not relatched.
  - STOP: no effect.
- ABORT from RUN or PAUSE: next state IDLE, dcount<=0, prescaler<=0, no expire.
- irq: set has priority over irq_ack when both occur on the same edge. Otherwise irq_ack clears it.
- Preload equal to terminal: the first step expires immediately.
- Latency, presc=0: START accepted at edge k → ARM → dcount=preld after edge k+1. First step at edge k+2.
- Latency, presc=p: steps occur every p+1 edges after entering RUN.
- All outputs are registered except busy and cmd_ready, which decode directly from state.

Decomposition:
- Package utimer_pkg:
  - state enum (IDLE, ARM, RUN, PAUSE)
  - cmd_op constants (OP_NOP, OP_START, OP_STOP, OP_ABORT)
  - default WIDTH/PRESC_W
  - terminal-value helper
- One sub-module, ucnt_core: WIDTH-bit register with load, enable and updown controls, plus an is_terminal output.
- utimer_ctrl8 contains the FSM, prescaler, shadow config and irq logic, and instantiates ucnt_core.

Test Plan:
- One-shot up, presc 0: START with preld=253, up, one-shot, presc=0 → dcount 253,254,255 on consecutive cycles. Next edge: expire pulse one cycle, irq=1, busy=0, dcount stays 255.
- Periodic down, presc 3: preld=2, down, periodic, presc=3 → dcount changes every 4 cycles: 2,1,0, then reload to 2. Expire pulses every 12 cycles; irq_ack between pulses clears irq; ack coincident with a pulse leaves irq=1.
- Pause/resume: STOP mid-count at dcount=100 → PAUSE, dcount held at 100 for 10 cycles. START → stepping resumes with prescaler phase preserved; a changed cfg_preld is ignored.
- Handshake: cmd_valid held with START during ARM → cmd_ready=0 for that cycle. The command is accepted the next cycle in RUN with no effect.
- ABORT vs terminal step: ABORT issued on the edge of a terminal step → IDLE, dcount=0, expire stays 0, irq unchanged.
- Reset mid-run: assert _areset asynchronously between edges in RUN at dcount=77 → immediately dcount=0, busy=0, irq=0, expire=0. After release, START works normally.

Source files
------------

// File: rtl/utimer_pkg.sv
// Shared types and constants for the utimer_ctrl8 interval timer.
package utimer_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_PRESC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  // Terminal count for the default width: all ones counting up, zero counting down.
  function automatic logic [DEF_WIDTH-1:0] term_val(input logic up);
    return up ? {DEF_WIDTH{1'b1}} : {DEF_WIDTH{1'b0}};
  endfunction

endpackage

// File: rtl/ucnt_core.sv
// Loadable up/down counter register with terminal-count detect.
module ucnt_core
  import utimer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             is_terminal
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over stepping.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign is_terminal = (count_q == {WIDTH{up}});

endmodule

// File: rtl/utimer_ctrl8.sv
// Interval-timer controller: command FSM, prescaler, shadow config and irq.
module utimer_ctrl8
  import utimer_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               _areset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cfg_preld,
  input  logic               cfg_updown,
  input  logic               cfg_periodic,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               irq_ack,
  output logic [WIDTH-1:0]   dcount,
  output logic               expire,
  output logic               irq,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]   sh_preld_q, sh_preld_d;
  logic               sh_up_q, sh_up_d;
  logic               sh_per_q, sh_per_d;
  logic [PRESC_W-1:0] sh_presc_q, sh_presc_d;
  logic               expire_q, expire_d;
  logic               irq_q, irq_d;

  logic               cnt_load;
  logic [WIDTH-1:0]   cnt_load_val;
  logic               cnt_en;
  logic               cnt_term;
  logic               accept;

  assign cmd_ready = (state_q != ST_ARM);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  ucnt_core #(.WIDTH(WIDTH)) u_cnt (
    .clk         (clk),
    .rst         (_areset),
    .load        (cnt_load),
    .load_val    (cnt_load_val),
    .en          (cnt_en),
    .up          (sh_up_q),
    .count       (dcount),
    .is_terminal (cnt_term)
  );

  // Next-state, prescaler, counter control and irq; ABORT beats STOP beats a due step.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    sh_preld_d   = sh_preld_q;
    sh_up_d      = sh_up_q;
    sh_per_d     = sh_per_q;
    sh_presc_d   = sh_presc_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    expire_d     = 1'b0;
    irq_d        = irq_ack ? 1'b0 : irq_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept && cmd_op == OP_START) begin
          sh_preld_d = cfg_preld;
          sh_up_d    = cfg_updown;
          sh_per_d   = cfg_periodic;
          sh_presc_d = cfg_presc;
          state_d    = ST_ARM;
        end
      end
      ST_ARM: begin
        cnt_load     = 1'b1;
        cnt_load_val = sh_preld_q;
        presc_d      = '0;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        if (accept && cmd_op == OP_ABORT) begin
          cnt_load = 1'b1;
          presc_d  = '0;
          state_d  = ST_IDLE;
        end else if (accept && cmd_op == OP_STOP) begin
          state_d = ST_PAUSE;
        end else if (presc_q == sh_presc_q) begin
          presc_d = '0;
          if (cnt_term) begin
            expire_d = 1'b1;
            irq_d    = 1'b1;
            if (sh_per_q) begin
              cnt_load     = 1'b1;
              cnt_load_val = sh_preld_q;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      ST_PAUSE: begin
        if (accept && cmd_op == OP_ABORT) begin
          cnt_load = 1'b1;
          presc_d  = '0;
          state_d  = ST_IDLE;
        end else if (accept && cmd_op == OP_START) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge _areset) begin
    if (_areset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      sh_preld_q <= '0;
      sh_up_q    <= 1'b0;
      sh_per_q   <= 1'b0;
      sh_presc_q <= '0;
      expire_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sh_preld_q <= sh_preld_d;
      sh_up_q    <= sh_up_d;
      sh_per_q   <= sh_per_d;
      sh_presc_q <= sh_presc_d;
      expire_q   <= expire_d;
      irq_q      <= irq_d;
    end
  end

  assign expire = expire_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_utimer_ctrl8.sv
// Randomized self-checking bench for utimer_ctrl8 against a behavioural timer model.
module tb_utimer_ctrl8;

  logic       clk = 1'b0;
  logic       areset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cfg_preld;
  logic       cfg_updown;
  logic       cfg_periodic;
  logic [3:0] cfg_presc;
  logic       irq_ack;
  logic [7:0] dcount;
  logic       expire;
  logic       irq;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model: a timer that is idle, arming, running or paused, with a countdown to the next step.
  bit m_arming, m_running, m_paused;
  int m_cnt, m_wait, m_expire, m_irq;
  int m_preld, m_up, m_per, m_presc;

  utimer_ctrl8 dut (
    .clk          (clk),
    ._areset      (areset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cfg_preld    (cfg_preld),
    .cfg_updown   (cfg_updown),
    .cfg_periodic (cfg_periodic),
    .cfg_presc    (cfg_presc),
    .irq_ack      (irq_ack),
    .dcount       (dcount),
    .expire       (expire),
    .irq          (irq),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_arming = 0; m_running = 0; m_paused = 0;
    m_cnt = 0; m_wait = 0; m_expire = 0; m_irq = 0;
    m_preld = 0; m_up = 0; m_per = 0; m_presc = 0;
  endtask

  task automatic check_all();
    check_eq("dcount", int'(dcount), m_cnt);
    check_eq("expire", int'(expire), m_expire);
    check_eq("irq", int'(irq), m_irq);
    check_eq("busy", int'(busy), int'(m_arming | m_running | m_paused));
    check_eq("cmd_ready", int'(cmd_ready), int'(!m_arming));
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit acc;
    bit fired;
    int term;
    acc      = cmd_valid && !m_arming;
    fired    = 0;
    m_expire = 0;
    if (m_arming) begin
      m_arming = 0; m_running = 1; m_cnt = m_preld; m_wait = m_presc;
    end else if (m_running) begin
      if (acc && cmd_op == 2'b11) begin
        m_running = 0; m_cnt = 0;
      end else if (acc && cmd_op == 2'b10) begin
        m_running = 0; m_paused = 1;
      end else if (m_wait > 0) begin
        m_wait--;
      end else begin
        m_wait = m_presc;
        term = m_up ? 255 : 0;
        if (m_cnt == term) begin
          fired = 1;
          if (m_per) m_cnt = m_preld;
          else m_running = 0;
        end else begin
          m_cnt = m_up ? m_cnt + 1 : m_cnt - 1;
        end
      end
    end else if (m_paused) begin
      if (acc && cmd_op == 2'b11) begin
        m_paused = 0; m_cnt = 0;
      end else if (acc && cmd_op == 2'b01) begin
        m_paused = 0; m_running = 1;
      end
    end else if (acc && cmd_op == 2'b01) begin
      m_arming = 1;
      m_preld = int'(cfg_preld); m_up = int'(cfg_updown);
      m_per = int'(cfg_periodic); m_presc = int'(cfg_presc);
    end
    if (fired) begin
      m_expire = 1; m_irq = 1;
    end else if (irq_ack) begin
      m_irq = 0;
    end
  endtask

  // Drive one cycle of inputs from a negedge, clock it and check at the next negedge.
  task automatic cyc(input bit v, input logic [1:0] op, input int pre, input bit ud,
                     input bit per, input int ps, input bit ack);
    cmd_valid = v; cmd_op = op; cfg_preld = 8'(pre); cfg_updown = ud;
    cfg_periodic = per; cfg_presc = 4'(ps); irq_ack = ack;
    check_eq("cmd_ready_pre", int'(cmd_ready), int'(!m_arming));
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  // Async reset asserted between edges; outputs must clear before any clock.
  task automatic async_reset();
    #2;
    areset = 1'b1;
    cmd_valid = 0; irq_ack = 0; cmd_op = 2'b00;
    #1;
    model_reset();
    check_eq("rst_dcount", int'(dcount), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_irq", int'(irq), 0);
    check_eq("rst_expire", int'(expire), 0);
    @(negedge clk);
    areset = 1'b0;
    check_all();
  endtask

  initial begin
    int pre, ps;
    bit ud;
    model_reset();
    areset = 1'b1; cmd_valid = 0; cmd_op = 2'b00; cfg_preld = 8'd0;
    cfg_updown = 0; cfg_periodic = 0; cfg_presc = 4'd0; irq_ack = 0;
    repeat (2) @(negedge clk);
    check_all();
    areset = 1'b0;
    idle_cycles(2);

    // One-shot up from 253: 253,254,255 then expire, irq, idle.
    cyc(1, 2'b01, 253, 1, 0, 0, 0);
    idle_cycles(5);
    check_eq("oneshot_hold", int'(dcount), 255);
    cyc(0, 2'b00, 0, 0, 0, 0, 1);

    // Periodic down with prescale 3, acks scattered including on pulses.
    cyc(1, 2'b01, 2, 0, 1, 3, 0);
    for (int i = 0; i < 40; i++) cyc(0, 2'b00, 0, 0, 0, 0, bit'(i % 5 == 2));
    cyc(1, 2'b11, 0, 0, 0, 0, 1);

    // Pause at 100, hold, resume with a different preload offered.
    cyc(1, 2'b01, 104, 0, 0, 2, 0);
    while (m_cnt != 100 || m_wait != 1) cyc(0, 2'b00, 0, 0, 0, 0, 0);
    cyc(1, 2'b10, 0, 0, 0, 0, 0);
    idle_cycles(10);
    check_eq("pause_hold", int'(dcount), 100);
    cyc(1, 2'b01, 7, 1, 1, 0, 0);
    idle_cycles(8);
    cyc(1, 2'b11, 0, 0, 0, 0, 0);

    // START held through ARM, then ABORT on the terminal step edge.
    cyc(1, 2'b01, 255, 1, 0, 0, 0);
    cyc(1, 2'b01, 0, 0, 0, 0, 0);
    check_eq("arm_ready", int'(cmd_ready), 1);
    cyc(1, 2'b11, 0, 0, 0, 0, 0);
    check_eq("abort_term_cnt", int'(dcount), 0);
    idle_cycles(2);

    // Mid-run async reset at 77, then a normal START.
    cyc(1, 2'b01, 80, 0, 0, 0, 0);
    idle_cycles(4);
    check_eq("pre_reset_cnt", int'(dcount), 77);
    async_reset();
    cyc(1, 2'b01, 254, 1, 1, 1, 0);
    idle_cycles(12);

    // Random traffic with terminal-biased configs and occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] op;
      int r;
      r  = $urandom_range(0, 99);
      op = (r < 50) ? 2'b01 : (r < 70) ? 2'b00 : (r < 85) ? 2'b10 : 2'b11;
      ud = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) pre = $urandom_range(0, 255);
      else pre = ud ? $urandom_range(250, 255) : $urandom_range(0, 5);
      ps = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      cyc(bit'($urandom_range(0, 5) == 0), op, pre, ud, bit'($urandom_range(0, 1)), ps,
          bit'($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 999) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
